// File: rtl/cpu_control_fsm_if.sv
// Control bundle between the CPU control FSM and the 16-bit datapath.
interface cpu_control_fsm_if;
   logic [15:0] ir_out;
   logic        z;
   logic        n;
   logic        pc_inc;
   logic [1:0]  pc_mux_sel;
   logic        ir_enable;
   logic        alu_sub;
   logic        alu_mux_a_sel;
   logic [2:0]  alu_mux_b_sel;
   logic [2:0]  rf_w_addr;
   logic        rf_write_en;
   logic        rf_only_high;
   logic [1:0]  rf_mux_sel;
   logic        mem_mux_sel;
   logic        z_en;
   logic        n_en;
   logic        o_mem_rd;
   logic        o_mem_wr;
   logic        o_instr_done;

   modport master (
      input  ir_out, z, n,
      output pc_inc, pc_mux_sel, ir_enable, alu_sub, alu_mux_a_sel, alu_mux_b_sel,
             rf_w_addr, rf_write_en, rf_only_high, rf_mux_sel, mem_mux_sel,
             z_en, n_en, o_mem_rd, o_mem_wr, o_instr_done
   );

   modport slave (
      output ir_out, z, n,
      input  pc_inc, pc_mux_sel, ir_enable, alu_sub, alu_mux_a_sel, alu_mux_b_sel,
             rf_w_addr, rf_write_en, rf_only_high, rf_mux_sel, mem_mux_sel,
             z_en, n_en, o_mem_rd, o_mem_wr, o_instr_done
   );
endinterface

// File: rtl/cpu_control_fsm.sv
// Multicycle control unit for the 16-bit CPU: sequences fetch/decode/execute/memory phases.
// Strobes are registered from the next state, so each one is valid for exactly its state.
module cpu_control_fsm #(
   parameter int unsigned MEM_RD_LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst,
   cpu_control_fsm_if.master bus
);

   typedef enum logic [2:0] {
      S_RESET  = 3'd0,
      S_FETCH  = 3'd1,
      S_FWAIT  = 3'd2,
      S_DECODE = 3'd3,
      S_EXEC   = 3'd4,
      S_LWAIT  = 3'd5
   } state_t;

   typedef struct packed {
      logic       pc_inc;
      logic [1:0] pc_mux_sel;
      logic       ir_enable;
      logic       alu_sub;
      logic       alu_mux_a_sel;
      logic [2:0] alu_mux_b_sel;
      logic [2:0] rf_w_addr;
      logic       rf_write_en;
      logic       rf_only_high;
      logic [1:0] rf_mux_sel;
      logic       mem_mux_sel;
      logic       z_en;
      logic       n_en;
      logic       mem_rd;
      logic       mem_wr;
      logic       instr_done;
   } ctrl_t;

   localparam ctrl_t      CTRL_IDLE = ctrl_t'(22'd0);
   localparam logic [2:0] LAST_WAIT = 3'(MEM_RD_LATENCY - 32'd1);

   localparam logic [3:0] OP_MV   = 4'd0;
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_CMP  = 4'd3;
   localparam logic [3:0] OP_LD   = 4'd4;
   localparam logic [3:0] OP_ST   = 4'd5;
   localparam logic [3:0] OP_MVHI = 4'd6;
   localparam logic [3:0] OP_JR   = 4'd8;
   localparam logic [3:0] OP_JZ   = 4'd9;
   localparam logic [3:0] OP_JN   = 4'd10;
   localparam logic [3:0] OP_CALL = 4'd12;

   state_t     state_r;
   state_t     state_nxt_s;
   logic [2:0] cnt_r;
   logic [2:0] cnt_nxt_s;
   ctrl_t      ctrl_r;
   ctrl_t      ctrl_nxt_s;

   // Strobes that belong to a given state/counter value for the current instruction.
   function automatic ctrl_t ctrl_for(input state_t st, input logic [2:0] cnt,
                                      input logic [15:0] ir, input logic zf, input logic nf);
      ctrl_t      c;
      logic [1:0] jsel;
      logic [2:0] bsel;
      c    = CTRL_IDLE;
      jsel = ir[4] ? 2'd1 : 2'd2;
      bsel = {2'b00, ir[4]};
      case (st)
         S_FETCH: begin
            c.mem_rd      = 1'b1;
            c.mem_mux_sel = 1'b0;
         end
         S_FWAIT: begin
            if (cnt == LAST_WAIT) begin
               c.ir_enable  = 1'b1;
               c.pc_inc     = 1'b1;
               c.pc_mux_sel = 2'd0;
            end else begin
               c = CTRL_IDLE;
            end
         end
         S_EXEC: begin
            c.instr_done = (ir[3:0] != OP_LD);
            case (ir[3:0])
               OP_MV: begin
                  c.alu_mux_a_sel = 1'b1;
                  c.alu_mux_b_sel = bsel;
                  c.rf_write_en   = 1'b1;
                  c.rf_w_addr     = ir[7:5];
               end
               OP_ADD, OP_SUB, OP_CMP: begin
                  c.alu_mux_b_sel = bsel;
                  c.alu_sub       = (ir[3:0] != OP_ADD);
                  c.rf_write_en   = (ir[3:0] != OP_CMP);
                  c.rf_w_addr     = ir[7:5];
                  c.z_en          = 1'b1;
                  c.n_en          = 1'b1;
               end
               OP_LD: begin
                  c.mem_rd      = 1'b1;
                  c.mem_mux_sel = 1'b1;
               end
               OP_ST: begin
                  c.mem_wr      = 1'b1;
                  c.mem_mux_sel = 1'b1;
               end
               OP_MVHI: begin
                  // Only the immediate form exists; the register form decodes as a no-op.
                  if (ir[4]) begin
                     c.alu_mux_a_sel = 1'b1;
                     c.alu_mux_b_sel = 3'd2;
                     c.rf_only_high  = 1'b1;
                     c.rf_write_en   = 1'b1;
                     c.rf_w_addr     = ir[7:5];
                  end else begin
                     c.rf_write_en = 1'b0;
                  end
               end
               OP_JR: begin
                  c.pc_inc     = 1'b1;
                  c.pc_mux_sel = jsel;
               end
               OP_JZ, OP_JN: begin
                  if ((ir[3:0] == OP_JZ) ? zf : nf) begin
                     c.pc_inc     = 1'b1;
                     c.pc_mux_sel = jsel;
                  end else begin
                     c.pc_inc = 1'b0;
                  end
               end
               OP_CALL: begin
                  c.pc_inc      = 1'b1;
                  c.pc_mux_sel  = jsel;
                  c.rf_write_en = 1'b1;
                  c.rf_w_addr   = 3'd7;
                  c.rf_mux_sel  = 2'd2;
               end
               default: c.instr_done = 1'b1;
            endcase
         end
         S_LWAIT: begin
            if (cnt == LAST_WAIT) begin
               c.rf_write_en = 1'b1;
               c.rf_mux_sel  = 2'd1;
               c.rf_w_addr   = ir[7:5];
               c.instr_done  = 1'b1;
            end else begin
               c = CTRL_IDLE;
            end
         end
         default: c = CTRL_IDLE;
      endcase
      return c;
   endfunction

   // Next-state, wait-counter and next-strobe computation.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      case (state_r)
         S_RESET:  state_nxt_s = S_FETCH;
         S_FETCH: begin
            state_nxt_s = S_FWAIT;
            cnt_nxt_s   = 3'd0;
         end
         S_FWAIT: begin
            if (cnt_r == LAST_WAIT) begin
               state_nxt_s = S_DECODE;
            end else begin
               cnt_nxt_s = cnt_r + 3'd1;
            end
         end
         S_DECODE: state_nxt_s = S_EXEC;
         S_EXEC: begin
            if (bus.ir_out[3:0] == OP_LD) begin
               state_nxt_s = S_LWAIT;
               cnt_nxt_s   = 3'd0;
            end else begin
               state_nxt_s = S_FETCH;
            end
         end
         S_LWAIT: begin
            if (cnt_r == LAST_WAIT) begin
               state_nxt_s = S_FETCH;
            end else begin
               cnt_nxt_s = cnt_r + 3'd1;
            end
         end
         default: state_nxt_s = S_RESET;
      endcase
      ctrl_nxt_s = ctrl_for(state_nxt_s, cnt_nxt_s, bus.ir_out, bus.z, bus.n);
   end

   // State, counter and strobe registers; reset clears all strobes without waiting for clk.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= S_RESET;
         cnt_r   <= 3'd0;
         ctrl_r  <= CTRL_IDLE;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         ctrl_r  <= ctrl_nxt_s;
      end
   end

   assign bus.pc_inc        = ctrl_r.pc_inc;
   assign bus.pc_mux_sel    = ctrl_r.pc_mux_sel;
   assign bus.ir_enable     = ctrl_r.ir_enable;
   assign bus.alu_sub       = ctrl_r.alu_sub;
   assign bus.alu_mux_a_sel = ctrl_r.alu_mux_a_sel;
   assign bus.alu_mux_b_sel = ctrl_r.alu_mux_b_sel;
   assign bus.rf_w_addr     = ctrl_r.rf_w_addr;
   assign bus.rf_write_en   = ctrl_r.rf_write_en;
   assign bus.rf_only_high  = ctrl_r.rf_only_high;
   assign bus.rf_mux_sel    = ctrl_r.rf_mux_sel;
   assign bus.mem_mux_sel   = ctrl_r.mem_mux_sel;
   assign bus.z_en          = ctrl_r.z_en;
   assign bus.n_en          = ctrl_r.n_en;
   assign bus.o_mem_rd      = ctrl_r.mem_rd;
   assign bus.o_mem_wr      = ctrl_r.mem_wr;
   assign bus.o_instr_done  = ctrl_r.instr_done;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Bench for cpu_control_fsm at MEM_RD_LATENCY 1 and 3: per-cycle strobe scoreboard fed by a
// timeline model of each instruction, plus asynchronous-reset checks.
module tb_cpu_control_fsm;

   typedef struct packed {
      logic       pc_inc;
      logic [1:0] pc_mux_sel;
      logic       ir_enable;
      logic       alu_sub;
      logic       alu_mux_a_sel;
      logic [2:0] alu_mux_b_sel;
      logic [2:0] rf_w_addr;
      logic       rf_write_en;
      logic       rf_only_high;
      logic [1:0] rf_mux_sel;
      logic       mem_mux_sel;
      logic       z_en;
      logic       n_en;
      logic       mem_rd;
      logic       mem_wr;
      logic       instr_done;
   } ctrl_t;

   localparam ctrl_t IDLE = ctrl_t'(22'd0);

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   ctrl_t       exp_q1[$];
   ctrl_t       exp_q3[$];
   logic [17:0] ir_q1[$];
   logic [17:0] ir_q3[$];
   ctrl_t       act1;
   ctrl_t       act3;

   cpu_control_fsm_if bus1();
   cpu_control_fsm_if bus3();

   cpu_control_fsm #(.MEM_RD_LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
   cpu_control_fsm #(.MEM_RD_LATENCY(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

   assign act1 = {bus1.pc_inc, bus1.pc_mux_sel, bus1.ir_enable, bus1.alu_sub, bus1.alu_mux_a_sel,
                  bus1.alu_mux_b_sel, bus1.rf_w_addr, bus1.rf_write_en, bus1.rf_only_high,
                  bus1.rf_mux_sel, bus1.mem_mux_sel, bus1.z_en, bus1.n_en, bus1.o_mem_rd,
                  bus1.o_mem_wr, bus1.o_instr_done};
   assign act3 = {bus3.pc_inc, bus3.pc_mux_sel, bus3.ir_enable, bus3.alu_sub, bus3.alu_mux_a_sel,
                  bus3.alu_mux_b_sel, bus3.rf_w_addr, bus3.rf_write_en, bus3.rf_only_high,
                  bus3.rf_mux_sel, bus3.mem_mux_sel, bus3.z_en, bus3.n_en, bus3.o_mem_rd,
                  bus3.o_mem_wr, bus3.o_instr_done};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // What the datapath must see in the execute cycle, straight from the opcode table.
   function automatic ctrl_t exec_ctrl(input logic [15:0] ir, input logic zf, input logic nf);
      ctrl_t      c;
      logic [3:0] op;
      logic       imm;
      logic [1:0] jump_src;
      c        = IDLE;
      op       = ir[3:0];
      imm      = ir[4];
      jump_src = imm ? 2'd1 : 2'd2;
      c.instr_done = 1'b1;
      if (op == 4'd0) begin
         c.alu_mux_a_sel = 1'b1; c.alu_mux_b_sel = imm ? 3'd1 : 3'd0;
         c.rf_write_en = 1'b1; c.rf_w_addr = ir[7:5];
      end else if (op == 4'd1 || op == 4'd2 || op == 4'd3) begin
         c.alu_mux_b_sel = imm ? 3'd1 : 3'd0;
         c.alu_sub = (op != 4'd1);
         c.rf_write_en = (op != 4'd3);
         c.rf_w_addr = ir[7:5];
         c.z_en = 1'b1; c.n_en = 1'b1;
      end else if (op == 4'd4) begin
         c.mem_rd = 1'b1; c.mem_mux_sel = 1'b1; c.instr_done = 1'b0;
      end else if (op == 4'd5) begin
         c.mem_wr = 1'b1; c.mem_mux_sel = 1'b1;
      end else if (op == 4'd6 && imm) begin
         c.alu_mux_a_sel = 1'b1; c.alu_mux_b_sel = 3'd2; c.rf_only_high = 1'b1;
         c.rf_write_en = 1'b1; c.rf_w_addr = ir[7:5];
      end else if (op == 4'd8 || (op == 4'd9 && zf) || (op == 4'd10 && nf)) begin
         c.pc_inc = 1'b1; c.pc_mux_sel = jump_src;
      end else if (op == 4'd12) begin
         c.pc_inc = 1'b1; c.pc_mux_sel = jump_src;
         c.rf_write_en = 1'b1; c.rf_w_addr = 3'd7; c.rf_mux_sel = 2'd2;
      end
      return c;
   endfunction

   // Whole-instruction timeline: fetch, L wait cycles, decode, execute, and L load cycles for ld.
   task automatic push_instr(input int lat, input logic [15:0] ir, input logic zf, input logic nf);
      ctrl_t seq[$];
      ctrl_t c;
      c = IDLE; c.mem_rd = 1'b1; seq.push_back(c);
      for (int i = 1; i <= lat; i++) begin
         c = IDLE;
         if (i == lat) begin c.ir_enable = 1'b1; c.pc_inc = 1'b1; end
         seq.push_back(c);
      end
      seq.push_back(IDLE);
      seq.push_back(exec_ctrl(ir, zf, nf));
      if (ir[3:0] == 4'd4) begin
         for (int i = 1; i <= lat; i++) begin
            c = IDLE;
            if (i == lat) begin
               c.rf_write_en = 1'b1; c.rf_mux_sel = 2'd1; c.rf_w_addr = ir[7:5]; c.instr_done = 1'b1;
            end
            seq.push_back(c);
         end
      end
      foreach (seq[k]) begin
         if (lat == 1) exp_q1.push_back(seq[k]);
         else          exp_q3.push_back(seq[k]);
      end
      if (lat == 1) ir_q1.push_back({nf, zf, ir});
      else          ir_q3.push_back({nf, zf, ir});
   endtask

   task automatic check_zero(input string name, input ctrl_t act);
      checks++;
      if (act !== IDLE) begin
         errors++;
         $display("FAIL %s: got strobes=%h required=%h", name, act, IDLE);
      end
   endtask

   task automatic wait_empty(input int budget);
      int n;
      n = 0;
      while ((exp_q1.size() != 0 || exp_q3.size() != 0) && n < budget) begin
         @(negedge clk); #1;
         n++;
      end
      if (exp_q1.size() != 0 || exp_q3.size() != 0) begin
         checks++; errors++;
         $display("FAIL drain_timeout: got %0d/%0d pending required 0", exp_q1.size(), exp_q3.size());
         exp_q1.delete(); exp_q3.delete();
      end
   endtask

   // Datapath stand-in for the L=1 core: loads the next instruction and its flags on ir_enable.
   initial begin : drv1
      logic        pend;
      logic [17:0] rec;
      bus1.ir_out = 16'd0; bus1.z = 1'b0; bus1.n = 1'b0;
      forever begin
         @(negedge clk);
         pend = bus1.ir_enable && rst;
         @(posedge clk); #1;
         if (pend && ir_q1.size() > 0) begin
            rec = ir_q1.pop_front();
            bus1.ir_out = rec[15:0]; bus1.z = rec[16]; bus1.n = rec[17];
         end
      end
   end

   initial begin : drv3
      logic        pend;
      logic [17:0] rec;
      bus3.ir_out = 16'd0; bus3.z = 1'b0; bus3.n = 1'b0;
      forever begin
         @(negedge clk);
         pend = bus3.ir_enable && rst;
         @(posedge clk); #1;
         if (pend && ir_q3.size() > 0) begin
            rec = ir_q3.pop_front();
            bus3.ir_out = rec[15:0]; bus3.z = rec[16]; bus3.n = rec[17];
         end
      end
   end

   // Monitors: every cycle with an expectation pending, compare all strobes of that core.
   initial begin : mon1
      ctrl_t e;
      int    cyc;
      cyc = 0;
      forever begin
         @(negedge clk);
         if (exp_q1.size() > 0) begin
            e = exp_q1.pop_front();
            checks++;
            if (act1 !== e) begin
               errors++;
               $display("FAIL l1_strobes cyc=%0d ir=%h: got %h required %h", cyc, bus1.ir_out, act1, e);
            end
            cyc++;
         end
      end
   end

   initial begin : mon3
      ctrl_t e;
      int    cyc;
      cyc = 0;
      forever begin
         @(negedge clk);
         if (exp_q3.size() > 0) begin
            e = exp_q3.pop_front();
            checks++;
            if (act3 !== e) begin
               errors++;
               $display("FAIL l3_strobes cyc=%0d ir=%h: got %h required %h", cyc, bus3.ir_out, act3, e);
            end
            cyc++;
         end
      end
   end

   initial begin : stim
      logic [31:0] r;
      checks = 0;
      errors = 0;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_zero("reset_l1", act1);
      check_zero("reset_l3", act3);
      #1;

      push_instr(1, 16'h8C51, 1'b0, 1'b0);
      push_instr(1, 16'h0164, 1'b0, 1'b0);
      push_instr(1, 16'h1239, 1'b0, 1'b1);
      push_instr(1, 16'h1239, 1'b1, 1'b0);
      push_instr(1, 16'h000C, 1'b0, 1'b0);
      push_instr(1, 16'h002A, 1'b0, 1'b1);
      push_instr(1, 16'hA5D6, 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) begin
         r = $urandom;
         push_instr(1, r[15:0], r[16], r[17]);
      end
      for (int i = 0; i < 3; i++) begin
         push_instr(3, 16'h0221, 1'b0, 1'b0);
         push_instr(3, 16'h0145, 1'b0, 1'b0);
      end
      for (int i = 0; i < 30; i++) begin
         r = $urandom;
         push_instr(3, r[15:0], r[16], r[17]);
      end
      rst = 1'b1;
      wait_empty(3000);

      rst = 1'b0;
      #1;
      check_zero("rst_async_l1", act1);
      check_zero("rst_async_l3", act3);
      repeat (2) @(negedge clk);
      #1;
      push_instr(1, 16'h8C51, 1'b0, 1'b0);
      push_instr(3, 16'h0164, 1'b0, 1'b0);
      void'(exp_q3.pop_back());
      rst = 1'b1;
      wait_empty(100);

      rst = 1'b0;
      #1;
      check_zero("rst_mid_lwait_l3", act3);
      check_zero("rst_mid_lwait_l1", act1);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check_zero("rst_hold_l3", act3);
      end
      #1;
      push_instr(3, 16'h0221, 1'b0, 1'b0);
      push_instr(1, 16'h0164, 1'b0, 1'b0);
      rst = 1'b1;
      #1;
      check_zero("release_no_edge_l3", act3);
      wait_empty(100);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
